// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: ID-stage instruction fields and pipeline status toward the
// controller; pipeline-register controls, forwarding selects and perf counters back.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16,
  parameter int REG_W = 3
);
  logic             id_valid;
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic [REG_W-1:0] id_rd;
  logic             id_reg_write;
  logic             id_mem_read;
  logic             ex_branch_taken;
  logic             mem_ready;

  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_bubble;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
    output id_rd, id_reg_write, id_mem_read, ex_branch_taken, mem_ready,
    input  pc_en, ifid_en, ifid_flush, idex_bubble, fwd_a, fwd_b,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
    input  id_rd, id_reg_write, id_mem_read, ex_branch_taken, mem_ready,
    output pc_en, ifid_en, ifid_flush, idex_bubble, fwd_a, fwd_b,
    output stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: stall/flush/bubble controls and EX forwarding are
// combinational in the same cycle; the shadow scoreboard advances next edge and holds while mem_ready=0.
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 16,
  parameter int REG_W = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  pipeline_hazard_ctrl_if.slave hz
);

  typedef logic [REG_W-1:0] reg_addr_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t rs1;
    reg_addr_t rs2;
    logic      rs1_used;
    logic      rs2_used;
    reg_addr_t rd;
    logic      reg_write;
    logic      mem_read;
  } ex_slot_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t rd;
    logic      reg_write;
    logic      mem_read;
  } mem_slot_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t rd;
    logic      reg_write;
  } wb_slot_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  localparam reg_addr_t        R0      = '0;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  ex_slot_t         ex_q;
  ex_slot_t         ex_d;
  mem_slot_t        mem_q;
  wb_slot_t         wb_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  logic freeze;
  logic flush;
  logic load_use;
  logic rs1_hit;
  logic rs2_hit;
  logic advance;
  logic stall_inc;
  logic flush_inc;
  logic [1:0] fwd_a_raw;
  logic [1:0] fwd_b_raw;

  // A load in MEM has no data yet, so only non-load producers forward from MEM.
  function automatic logic [1:0] fwd_select(
    input reg_addr_t rs,
    input logic      used,
    input mem_slot_t m,
    input wb_slot_t  w
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (used && rs != R0) begin
      if (m.valid && m.reg_write && !m.mem_read && m.rd == rs)
        sel = FWD_MEM;
      else if (w.valid && w.reg_write && w.rd == rs)
        sel = FWD_WB;
    end
    return sel;
  endfunction

  always_comb begin
    rs1_hit  = hz.id_rs1_used && (hz.id_rs1 == ex_q.rd);
    rs2_hit  = hz.id_rs2_used && (hz.id_rs2 == ex_q.rd);
    freeze   = !hz.mem_ready;
    flush    = hz.ex_branch_taken && ex_q.valid;
    load_use = hz.id_valid && ex_q.valid && ex_q.mem_read && ex_q.reg_write &&
               (ex_q.rd != R0) && (rs1_hit || rs2_hit);
  end

  always_comb begin
    hz.pc_en       = 1'b1;
    hz.ifid_en     = 1'b1;
    hz.ifid_flush  = 1'b0;
    hz.idex_bubble = 1'b0;
    advance        = 1'b1;
    stall_inc      = 1'b0;
    flush_inc      = 1'b0;
    if (reset) begin
      hz.pc_en       = 1'b0;
      hz.ifid_en     = 1'b0;
      hz.ifid_flush  = 1'b1;
      hz.idex_bubble = 1'b1;
      advance        = 1'b0;
    end else if (freeze) begin
      hz.pc_en       = 1'b0;
      hz.ifid_en     = 1'b0;
      advance        = 1'b0;
      stall_inc      = 1'b1;
    end else if (flush) begin
      hz.ifid_flush  = 1'b1;
      hz.idex_bubble = 1'b1;
      flush_inc      = 1'b1;
    end else if (load_use) begin
      hz.pc_en       = 1'b0;
      hz.ifid_en     = 1'b0;
      hz.idex_bubble = 1'b1;
      stall_inc      = 1'b1;
    end
  end

  always_comb begin
    ex_d = '0;
    if (!hz.idex_bubble) begin
      ex_d.valid     = hz.id_valid;
      ex_d.rs1       = hz.id_rs1;
      ex_d.rs2       = hz.id_rs2;
      ex_d.rs1_used  = hz.id_rs1_used;
      ex_d.rs2_used  = hz.id_rs2_used;
      ex_d.rd        = hz.id_rd;
      ex_d.reg_write = hz.id_reg_write;
      ex_d.mem_read  = hz.id_mem_read;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (advance) begin
        ex_q            <= ex_d;
        mem_q.valid     <= ex_q.valid;
        mem_q.rd        <= ex_q.rd;
        mem_q.reg_write <= ex_q.reg_write;
        mem_q.mem_read  <= ex_q.mem_read;
        wb_q.valid      <= mem_q.valid;
        wb_q.rd         <= mem_q.rd;
        wb_q.reg_write  <= mem_q.reg_write;
      end
      if (stall_inc && stall_cnt_q != CNT_MAX)
        stall_cnt_q <= stall_cnt_q + CNT_ONE;
      if (flush_inc && flush_cnt_q != CNT_MAX)
        flush_cnt_q <= flush_cnt_q + CNT_ONE;
    end
  end

  // Forwarding follows the shadow alone, so it stays meaningful during a freeze.
  always_comb begin
    fwd_a_raw = fwd_select(ex_q.rs1, ex_q.rs1_used, mem_q, wb_q);
    fwd_b_raw = fwd_select(ex_q.rs2, ex_q.rs2_used, mem_q, wb_q);
    hz.fwd_a  = FWD_RF;
    hz.fwd_b  = FWD_RF;
    if (!reset && ex_q.valid) begin
      hz.fwd_a = fwd_a_raw;
      hz.fwd_b = fwd_b_raw;
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;

endmodule
